// File: rtl/avm_debug_hub_pkg.sv
// Shared constants and types for the Avalon-MM debug hub: register offsets,
// command codes and the CPU control state encoding.
package avm_debug_pkg;

   localparam logic [19:0] ADDR_STATUS   = 20'h00100;
   localparam logic [19:0] ADDR_CMD      = 20'h00104;
   localparam logic [19:0] ADDR_STEP_CNT = 20'h00108;
   localparam logic [19:0] ADDR_BP_BASE  = 20'h00110;

   localparam logic [7:0] CMD_HALT   = 8'h00;
   localparam logic [7:0] CMD_RUN    = 8'h01;
   localparam logic [7:0] CMD_STEP   = 8'h02;
   localparam logic [7:0] CMD_CLR_BP = 8'h03;

   localparam logic [31:0] READ_DEFAULT = 32'hDEADBEEF;

   typedef enum logic [1:0] {
      CTRL_RUN,
      CTRL_HALT_PEND,
      CTRL_STEP,
      CTRL_HALTED
   } ctrl_state_t;

   function automatic logic [17:0] word_of(input logic [19:0] byte_addr);
      return byte_addr[19:2];
   endfunction

endpackage

// File: rtl/avm_debug_hub_if.sv
// Avalon-MM bridge signals between the HPS bridge master and the debug hub.
interface avm_debug_hub_if;

   logic [19:0] address;
   logic        read;
   logic        write;
   logic [6:0]  burstcount;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic        waitrequest;
   logic [31:0] readdata;
   logic        readdatavalid;

   modport master (
      output address, read, write, burstcount, writedata, byteenable,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, read, write, burstcount, writedata, byteenable,
      output waitrequest, readdata, readdatavalid
   );

endinterface

// File: rtl/avm_debug_hub_bp_cmp.sv
// One address breakpoint: enable/address registers and a match pulse that
// fires on the cycle a CPU bus cycle starts at the programmed address.
module avm_debug_bp_cmp #(
   parameter int CPU_AW = 24
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              wr_en,
   input  logic              wr_enable,
   input  logic [CPU_AW-1:0] wr_addr,
   input  logic              as_fall,
   input  logic [CPU_AW-1:0] cpu_addr,
   output logic              match,
   output logic [31:0]       rdata
);

   logic              enable;
   logic [CPU_AW-1:0] bp_addr;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         enable  <= 1'b0;
         bp_addr <= '0;
      end else if (wr_en) begin
         enable  <= wr_enable;
         bp_addr <= wr_addr;
      end
   end

   assign match = enable && as_fall && (cpu_addr == bp_addr);
   assign rdata = {enable, 31'(bp_addr)};

endmodule

// File: rtl/avm_debug_hub.sv
// Avalon-MM debug slave: burst reads of probe words, halt/run/step gating of
// the 68k clock enable, and address breakpoints checked at bus-cycle start.
module avm_debug_hub
   import avm_debug_pkg::*;
#(
   parameter int NUM_REGS = 8,
   parameter int NUM_BP   = 4,
   parameter int CPU_AW   = 24,
   parameter int STEP_W   = 16
) (
   input  logic                  clk_sys,
   input  logic                  reset_n,
   output logic                  bridge_m0_clk,
   avm_debug_hub_if.slave        bridge_m0,
   input  logic                  cpu_as_n,
   input  logic [CPU_AW-1:0]     cpu_addr,
   input  logic [NUM_REGS*32-1:0] probe_regs,
   output logic                  cpu_clken_dbg,
   output logic                  halted,
   output logic                  bp_hit
);

   logic [17:0] req_word;
   logic        rd_accept;
   logic        wr_accept;
   logic        as_q;
   logic        as_rise;
   logic        as_fall;
   logic        unused_bits;

   assign bridge_m0_clk = clk_sys;
   assign req_word      = word_of(bridge_m0.address);
   assign rd_accept     = bridge_m0.read && !bridge_m0.waitrequest;
   assign wr_accept     = bridge_m0.write && !bridge_m0.read && !bridge_m0.waitrequest;
   assign unused_bits   = ^{bridge_m0.byteenable, bridge_m0.address[1:0], bridge_m0.writedata};

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) as_q <= 1'b1;
      else          as_q <= cpu_as_n;
   end

   assign as_rise = cpu_as_n && !as_q;
   assign as_fall = !cpu_as_n && as_q;

   logic [NUM_BP-1:0] bp_match;
   logic [31:0]       bp_rdata [NUM_BP];

   for (genvar k = 0; k < NUM_BP; k++) begin : g_bp
      avm_debug_bp_cmp #(.CPU_AW(CPU_AW)) u_bp (
         .clk_sys   (clk_sys),
         .reset_n   (reset_n),
         .wr_en     (wr_accept && (req_word == word_of(ADDR_BP_BASE) + 18'(k))),
         .wr_enable (bridge_m0.writedata[31]),
         .wr_addr   (bridge_m0.writedata[CPU_AW-1:0]),
         .as_fall   (as_fall),
         .cpu_addr  (cpu_addr),
         .match     (bp_match[k]),
         .rdata     (bp_rdata[k])
      );
   end

   // Lowest-numbered matching breakpoint is the one reported.
   logic       any_match;
   logic [2:0] match_idx;

   always_comb begin
      any_match = 1'b0;
      match_idx = 3'd0;
      for (int k = NUM_BP - 1; k >= 0; k--) begin
         if (bp_match[k]) begin
            any_match = 1'b1;
            match_idx = 3'(k);
         end
      end
   end

   ctrl_state_t       state, state_next;
   logic [STEP_W-1:0] step_left, step_left_next;
   logic [STEP_W-1:0] step_cnt, step_cnt_next;
   logic              bp_hit_q, bp_hit_next;
   logic [2:0]        hit_idx, hit_idx_next;
   logic              cmd_wr;
   logic [7:0]        cmd_code;
   logic              bp_armed;
   logic [STEP_W-1:0] step_load;

   assign cmd_wr    = wr_accept && (req_word == word_of(ADDR_CMD));
   assign cmd_code  = bridge_m0.writedata[31:24];
   assign step_load = (step_cnt == '0) ? STEP_W'(1) : step_cnt;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state     <= CTRL_RUN;
         step_left <= '0;
         step_cnt  <= '0;
         bp_hit_q  <= 1'b0;
         hit_idx   <= 3'd0;
      end else begin
         state     <= state_next;
         step_left <= step_left_next;
         step_cnt  <= step_cnt_next;
         bp_hit_q  <= bp_hit_next;
         hit_idx   <= hit_idx_next;
      end
   end

   // A command write arriving with a breakpoint match takes the state
   // transition, but the hit is still recorded.
   always_comb begin
      state_next     = state;
      step_left_next = step_left;
      step_cnt_next  = step_cnt;
      bp_hit_next    = bp_hit_q;
      hit_idx_next   = hit_idx;
      bp_armed       = any_match && (state == CTRL_RUN || state == CTRL_STEP);

      if (wr_accept && (req_word == word_of(ADDR_STEP_CNT)))
         step_cnt_next = bridge_m0.writedata[STEP_W-1:0];
      if (cmd_wr && cmd_code == CMD_CLR_BP)
         bp_hit_next = 1'b0;
      if (bp_armed) begin
         bp_hit_next  = 1'b1;
         hit_idx_next = match_idx;
      end

      unique case (state)
         CTRL_RUN: begin
            if (cmd_wr && cmd_code == CMD_HALT) state_next = CTRL_HALT_PEND;
            else if (cmd_wr && cmd_code == CMD_STEP) begin
               state_next     = CTRL_STEP;
               step_left_next = step_load;
            end else if (bp_armed) state_next = CTRL_HALT_PEND;
         end
         CTRL_HALT_PEND: begin
            if (cmd_wr && cmd_code == CMD_RUN) state_next = CTRL_RUN;
            else if (as_rise)                  state_next = CTRL_HALTED;
         end
         CTRL_STEP: begin
            if (cmd_wr && cmd_code == CMD_HALT) state_next = CTRL_HALT_PEND;
            else if (bp_armed)                  state_next = CTRL_HALT_PEND;
            else if (as_rise) begin
               step_left_next = step_left - STEP_W'(1);
               if (step_left <= STEP_W'(1)) state_next = CTRL_HALTED;
            end
         end
         CTRL_HALTED: begin
            if (cmd_wr && cmd_code == CMD_RUN) state_next = CTRL_RUN;
            else if (cmd_wr && cmd_code == CMD_STEP) begin
               state_next     = CTRL_STEP;
               step_left_next = step_load;
            end
         end
         default: state_next = CTRL_RUN;
      endcase
   end

   assign cpu_clken_dbg = (state != CTRL_HALTED);
   assign halted        = (state == CTRL_HALTED);
   assign bp_hit        = bp_hit_q;

   logic [31:0] status_word;
   logic [17:0] rd_next;
   logic [6:0]  rd_left;
   logic [17:0] sel_word;
   logic [31:0] rd_word;

   assign status_word = {16'(step_left), 5'd0, hit_idx, 4'd0, bp_hit_q,
                         state == CTRL_STEP, state == CTRL_HALT_PEND, state == CTRL_HALTED};
   assign sel_word    = bridge_m0.waitrequest ? rd_next : req_word;

   always_comb begin
      rd_word = READ_DEFAULT;
      for (int i = 0; i < NUM_REGS; i++)
         if (sel_word == 18'(i)) rd_word = probe_regs[32*i +: 32];
      if (sel_word == word_of(ADDR_STATUS))   rd_word = status_word;
      if (sel_word == word_of(ADDR_STEP_CNT)) rd_word = 32'(step_cnt);
      for (int k = 0; k < NUM_BP; k++)
         if (sel_word == word_of(ADDR_BP_BASE) + 18'(k)) rd_word = bp_rdata[k];
   end

   // The first beat is captured on the accept edge; waitrequest covers every beat.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         bridge_m0.waitrequest   <= 1'b0;
         bridge_m0.readdatavalid <= 1'b0;
         bridge_m0.readdata      <= '0;
         rd_next                 <= '0;
         rd_left                 <= '0;
      end else if (rd_accept) begin
         bridge_m0.waitrequest   <= 1'b1;
         bridge_m0.readdatavalid <= 1'b1;
         bridge_m0.readdata      <= rd_word;
         rd_next                 <= req_word + 18'd1;
         rd_left                 <= (bridge_m0.burstcount == 7'd0) ? 7'd0 : bridge_m0.burstcount - 7'd1;
      end else if (bridge_m0.waitrequest) begin
         if (rd_left != 7'd0) begin
            bridge_m0.readdatavalid <= 1'b1;
            bridge_m0.readdata      <= rd_word;
            rd_next                 <= rd_next + 18'd1;
            rd_left                 <= rd_left - 7'd1;
         end else begin
            bridge_m0.waitrequest   <= 1'b0;
            bridge_m0.readdatavalid <= 1'b0;
         end
      end else begin
         bridge_m0.readdatavalid <= 1'b0;
      end
   end

endmodule
